// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying NCH write channels plus valid; 1-cycle latency, no comb in->out path.
// Backpressure: stall[STAGE] with stall[STAGE+1] holds, without it a bubble is inserted; flush squashes.
module pipe_stage_reg #(
  parameter int STAGE   = 4,
  parameter int STALL_W = 6,
  parameter int NCH     = 3,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 clr_cnt,
  input  logic                 in_valid,
  input  logic [NCH-1:0]       in_we,
  input  logic [NCH*AW-1:0]    in_addr,
  input  logic [NCH*DW-1:0]    in_data,
  output logic                 out_valid,
  output logic [NCH-1:0]       out_we,
  output logic [NCH*AW-1:0]    out_addr,
  output logic [NCH*DW-1:0]    out_data,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef enum logic [1:0] {
    M_ADVANCE,
    M_HOLD,
    M_BUBBLE,
    M_FLUSH
  } mode_e;

  // The last stage has no downstream stall bit, so it can only bubble, never hold.
  localparam bit HAS_DN = (STAGE + 1 < STALL_W);
  localparam int DN_IDX = HAS_DN ? STAGE + 1 : STAGE;

  logic  st;
  logic  dn;
  logic  stall_unused;
  mode_e mode;

  assign st           = stall[STAGE];
  assign dn           = HAS_DN ? stall[DN_IDX] : 1'b0;
  assign stall_unused = ^stall;

  always_comb begin
    mode = M_ADVANCE;
    if (flush)
      mode = M_FLUSH;
    else if (st && !dn)
      mode = M_BUBBLE;
    else if (st)
      mode = M_HOLD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_we    <= '0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      case (mode)
        M_FLUSH, M_BUBBLE: begin
          out_valid <= 1'b0;
          out_we    <= '0;
          out_addr  <= '0;
          out_data  <= '0;
        end
        M_ADVANCE: begin
          out_valid <= in_valid;
          out_we    <= in_we & {NCH{in_valid}};
          out_addr  <= in_valid ? in_addr : '0;
          out_data  <= in_valid ? in_data : '0;
        end
        default: ;
      endcase
    end
  end

  // Clear wins over the increment of the same cycle; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (clr_cnt) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (mode == M_BUBBLE && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (mode == M_FLUSH && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: default stage, a 2-bit-counter stage and a last stage share the same stimulus.
module tb_pipe_stage_reg;

  localparam int NCH = 3;
  localparam int AW  = 5;
  localparam int DW  = 32;

  logic              clk;
  logic              rst;
  logic [5:0]        stall;
  logic              flush;
  logic              clr_cnt;
  logic              in_valid;
  logic [NCH-1:0]    in_we;
  logic [NCH*AW-1:0] in_addr;
  logic [NCH*DW-1:0] in_data;

  logic              d_valid, s_valid, l_valid;
  logic [NCH-1:0]    d_we, s_we, l_we;
  logic [NCH*AW-1:0] d_addr, s_addr, l_addr;
  logic [NCH*DW-1:0] d_data, s_data, l_data;
  logic [15:0]       d_bcnt, d_fcnt, l_bcnt, l_fcnt;
  logic [1:0]        s_bcnt, s_fcnt;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_stage_reg u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .out_valid(d_valid), .out_we(d_we), .out_addr(d_addr), .out_data(d_data),
    .bubble_cnt(d_bcnt), .flush_cnt(d_fcnt)
  );

  pipe_stage_reg #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .out_valid(s_valid), .out_we(s_we), .out_addr(s_addr), .out_data(s_data),
    .bubble_cnt(s_bcnt), .flush_cnt(s_fcnt)
  );

  pipe_stage_reg #(.STAGE(5)) u_last (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .out_valid(l_valid), .out_we(l_we), .out_addr(l_addr), .out_data(l_data),
    .bubble_cnt(l_bcnt), .flush_cnt(l_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] we,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    in_valid = v;
    in_we    = we;
    in_addr  = {a2, a1, a0};
    in_data  = {d2, d1, d0};
  endtask

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0; clr_cnt = 1'b0;
    drive(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick(); tick();

    // Asynchronous reset between edges
    drive(1'b1, 3'b111, 5'd31, 5'd17, 5'd9, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hCAFEF00D);
    rst = 1'b1;
    tick();
    chk("preload_valid", d_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", d_valid, 1'b0);
    chk("rst_we",    d_we, 3'b000);
    chk("rst_addr",  d_addr, 15'h0);
    chk("rst_data",  d_data, 96'h0);
    chk("rst_bcnt",  d_bcnt, 16'h0);
    chk("rst_fcnt",  d_fcnt, 16'h0);
    rst = 1'b1;

    // Advance with a sparse enable set
    drive(1'b1, 3'b101, 5'd3, 5'd0, 5'd7, 32'hDEADBEEF, 32'h00005555, 32'h00001234);
    tick();
    chk("adv_valid",    d_valid, 1'b1);
    chk("adv_we",       d_we, 3'b101);
    chk("adv_ch0_addr", d_addr[4:0], 5'd3);
    chk("adv_ch2_addr", d_addr[14:10], 5'd7);
    chk("adv_ch0_data", d_data[31:0], 32'hDEADBEEF);
    chk("adv_ch1_data", d_data[63:32], 32'h00005555);
    chk("adv_ch2_data", d_data[95:64], 32'h00001234);

    // Invalid input clears enables and payload
    in_valid = 1'b0;
    tick();
    chk("inv_valid", d_valid, 1'b0);
    chk("inv_we",    d_we, 3'b000);
    chk("inv_addr",  d_addr, 15'h0);
    chk("inv_data",  d_data, 96'h0);

    // Hold for three cycles, then bubble
    drive(1'b1, 3'b011, 5'd1, 5'd2, 5'd4, 32'h11111111, 32'h22222222, 32'h33333333);
    tick();
    chk("hold_pre_we", d_we, 3'b011);
    stall = 6'b110000;
    drive(1'b1, 3'b100, 5'd9, 5'd9, 5'd9, 32'h99999999, 32'h88888888, 32'h77777777);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_we",   d_we, 3'b011);
      chk("hold_addr", d_addr, {5'd4, 5'd2, 5'd1});
      chk("hold_data", d_data, {32'h33333333, 32'h22222222, 32'h11111111});
    end
    chk("hold_bcnt",       d_bcnt, 16'd0);
    chk("last_no_hold_v",  l_valid, 1'b0);
    chk("last_no_hold_we", l_we, 3'b000);
    chk("last_bcnt",       l_bcnt, 16'd3);
    stall = 6'b010000;
    tick();
    chk("bub_valid", d_valid, 1'b0);
    chk("bub_we",    d_we, 3'b000);
    chk("bub_data",  d_data, 96'h0);
    chk("bub_bcnt",  d_bcnt, 16'd1);
    chk("sat_bcnt1", s_bcnt, 2'd1);

    // Flush beats a same-cycle bubble
    stall = 6'b000000;
    tick();
    chk("fl_pre_valid", d_valid, 1'b1);
    flush = 1'b1;
    stall = 6'b010000;
    tick();
    chk("fl_valid", d_valid, 1'b0);
    chk("fl_addr",  d_addr, 15'h0);
    chk("fl_data",  d_data, 96'h0);
    chk("fl_fcnt",  d_fcnt, 16'd1);
    chk("fl_bcnt",  d_bcnt, 16'd1);
    flush = 1'b0;

    // Counter clear leaves the payload path alone
    stall = 6'b000000;
    clr_cnt = 1'b1;
    tick();
    chk("clr_bcnt",  d_bcnt, 16'd0);
    chk("clr_fcnt",  d_fcnt, 16'd0);
    chk("clr_sfcnt", s_fcnt, 2'd0);
    chk("clr_valid", d_valid, 1'b1);
    chk("clr_we",    d_we, 3'b100);
    clr_cnt = 1'b0;

    // Saturation of the 2-bit counter
    stall = 6'b010000;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_bcnt",  s_bcnt, 2'd3);
    chk("nsat_bcnt", d_bcnt, 16'd5);
    clr_cnt = 1'b1;
    tick();
    chk("sat_clr_bcnt", s_bcnt, 2'd0);
    chk("clr_bub_bcnt", d_bcnt, 16'd0);
    clr_cnt = 1'b0;

    // Stall bits outside STAGE/STAGE+1 do nothing
    stall = 6'b001111;
    drive(1'b1, 3'b010, 5'd5, 5'd6, 5'd7, 32'h1, 32'h2, 32'h3);
    tick();
    chk("ign_valid", d_valid, 1'b1);
    chk("ign_we",    d_we, 3'b010);
    chk("ign_bcnt",  d_bcnt, 16'd0);

    // Reset during hold empties the stage
    stall = 6'b110000;
    tick();
    chk("rh_hold_we", d_we, 3'b010);
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    chk("rh_valid", d_valid, 1'b0);
    chk("rh_we",    d_we, 3'b000);
    chk("rh_data",  d_data, 96'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
